multi_timer: RTL and testbench

Multi-channel bus timer peripheral; the parametrised successor to the single-channel 1 ms bus timer. It has one shared prescaler and a free-running tick counter, plus up to four independent compare channels. Each channel is periodic or one-shot and sets a sticky per-channel pending flag. It sits on the 8-bit processor bus with the other memory-mapped peripherals and drives the processor's timer interrupt line.

---
 rtl/multi_timer_if.sv | 22 ++
 rtl/multi_timer.sv | 172 +++++++++++++++++
 tb/tb_multi_timer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_timer_if.sv
// Processor-side bus signals of the multi-channel timer: address, write strobe
// and the interrupt request/acknowledge pair. The tristate data bus stays a plain port.
interface multi_timer_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;

    modport master (
        output BUS_ADDR,
        output BUS_WE,
        output BUS_INTERRUPT_ACK,
        input  BUS_INTERRUPT_RAISE
    );

    modport slave (
        input  BUS_ADDR,
        input  BUS_WE,
        input  BUS_INTERRUPT_ACK,
        output BUS_INTERRUPT_RAISE
    );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel bus timer: shared prescaler, free-running tick counter and up to
// four periodic/one-shot compare channels with sticky pending flags and one IRQ line.
module multi_timer #(
    parameter logic [7:0] BASE_ADDR      = 8'hF0,
    parameter int         CHANNELS       = 2,
    parameter int         TICK_DIV       = 50000,
    parameter int         COUNT_W        = 16,
    parameter int         DEFAULT_PERIOD = 100,
    parameter bit         CH0_ENABLE     = 1'b1
) (
    input  logic         CLK,
    input  logic         RESET,
    inout  wire  [7:0]   BUS_DATA,
    multi_timer_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]      r_presc;
    logic [COUNT_W-1:0] r_timer;
    logic               r_overrun;
    logic               r_irq;
    logic [7:0]         r_rd_data;
    logic               r_rd_en;

    logic [7:0]          w_off;
    logic                w_mapped;
    logic                w_wr;
    logic                w_rd;
    logic                w_tick;
    logic                w_wr_timer;
    logic                w_wr_status;
    logic [7:0]          w_wdata;
    logic [7:0]          w_status;
    logic [7:0]          w_rd_mux;
    logic [CHANNELS-1:0] w_fire;
    logic [CHANNELS-1:0] w_pend;
    logic [7:0]          w_period [CHANNELS];
    logic [1:0]          w_ctrl   [CHANNELS];

    assign w_off       = bus.BUS_ADDR - BASE_ADDR;
    assign w_mapped    = (bus.BUS_ADDR >= BASE_ADDR) && (w_off <= 8'd10);
    assign w_wr        = w_mapped && bus.BUS_WE;
    assign w_rd        = w_mapped && !bus.BUS_WE;
    assign w_wdata     = BUS_DATA;
    assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
    assign w_wr_timer  = w_wr && (w_off == 8'd0);
    assign w_wr_status = w_wr && (w_off == 8'd10);
    assign w_status    = 8'(w_pend) | {r_overrun, 7'b0};

    // A timer-clear write beats the tick on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET || w_wr_timer) begin
            r_presc <= '0;
            r_timer <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_timer <= r_timer + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [7:0] r_period;
            logic [7:0] r_cnt;
            logic       r_en;
            logic       r_oneshot;
            logic       r_pending;

            wire w_wr_period = w_wr && (w_off == 8'(2 + 2 * gi));
            wire w_wr_ctrl   = w_wr && (w_off == 8'(3 + 2 * gi));
            wire w_run       = w_tick && r_en && (r_period != 8'd0);
            wire w_match     = ((r_cnt + 8'd1) == r_period);

            // Register writes take priority over a coincident tick and suppress its event.
            assign w_fire[gi]   = w_run && w_match && !w_wr_period && !w_wr_ctrl;
            assign w_pend[gi]   = r_pending;
            assign w_period[gi] = r_period;
            assign w_ctrl[gi]   = {r_oneshot, r_en};

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_period  <= 8'(DEFAULT_PERIOD);
                    r_cnt     <= 8'd0;
                    r_en      <= (gi == 0) && CH0_ENABLE;
                    r_oneshot <= 1'b0;
                end else if (w_wr_period) begin
                    r_period <= w_wdata;
                    r_cnt    <= 8'd0;
                end else if (w_wr_ctrl) begin
                    r_en      <= w_wdata[0];
                    r_oneshot <= w_wdata[1];
                    if ((!r_en && w_wdata[0]) || w_tick) begin
                        r_cnt <= 8'd0;
                    end
                end else if (w_run) begin
                    if (w_match) begin
                        r_cnt <= 8'd0;
                        if (r_oneshot) begin
                            r_en <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_pending <= 1'b0;
                end else if (w_fire[gi]) begin
                    r_pending <= 1'b1;
                end else if (w_wr_status && w_wdata[gi]) begin
                    r_pending <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_overrun <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (|(w_fire & w_pend)) begin
                r_overrun <= 1'b1;
            end else if (w_wr_status && w_wdata[7]) begin
                r_overrun <= 1'b0;
            end
            if (|w_fire) begin
                r_irq <= 1'b1;
            end else if (bus.BUS_INTERRUPT_ACK) begin
                r_irq <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_mux = 8'd0;
        case (w_off)
            8'd0:    w_rd_mux = r_timer[7:0];
            8'd1:    w_rd_mux = 8'(r_timer >> 8);
            8'd10:   w_rd_mux = w_status;
            default: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (w_off == 8'(2 + 2 * c)) w_rd_mux = w_period[c];
                    if (w_off == 8'(3 + 2 * c)) w_rd_mux = {6'b0, w_ctrl[c]};
                end
            end
        endcase
    end

    // Read data is captured from pre-edge state and driven for exactly one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rd_en   <= 1'b0;
            r_rd_data <= 8'd0;
        end else begin
            r_rd_en <= w_rd;
            if (w_rd) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign BUS_DATA                = r_rd_en ? r_rd_data : 8'bz;
    assign bus.BUS_INTERRUPT_RAISE = r_irq;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus random bus traffic, all checked
// against a register-level reference model of the timer rules.
module tb_multi_timer;
    localparam logic [7:0] BASE = 8'hF0;
    localparam int CH = 2;
    localparam int TD = 4;
    localparam int CW = 9;
    localparam int DP = 100;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    wire  [7:0] BUS_DATA;
    logic [7:0] r_wdata = 8'd0;
    logic       r_drv = 1'b0;

    assign BUS_DATA = r_drv ? r_wdata : 8'bz;
    wire bus_float = (BUS_DATA === 8'bz);

    multi_timer_if bus_if();

    multi_timer #(
        .BASE_ADDR(BASE), .CHANNELS(CH), .TICK_DIV(TD), .COUNT_W(CW),
        .DEFAULT_PERIOD(DP), .CH0_ENABLE(1'b1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .BUS_DATA(BUS_DATA), .bus(bus_if.slave)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err = 0;

    // Reference model state
    int m_presc, m_timer;
    int m_period [CH];
    int m_cnt    [CH];
    bit m_en     [CH];
    bit m_os     [CH];
    bit m_pend   [CH];
    bit m_ovr, m_irq;

    logic [7:0] last_rd;
    bit         last_was_read;
    bit         prev_raise;
    int         rises;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_mapped(input logic [7:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) - int'(BASE) <= 10);
    endfunction

    function automatic int m_read(input logic [7:0] a);
        int off = int'(a) - int'(BASE);
        int v = 0;
        if (!m_mapped(a)) return 0;
        if (off == 0) v = m_timer % 256;
        else if (off == 1) v = m_timer / 256;
        else if (off == 10) begin
            v = m_ovr ? 128 : 0;
            for (int c = 0; c < CH; c++) if (m_pend[c]) v += (1 << c);
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (off == 2 + 2 * c) v = m_period[c];
                if (off == 3 + 2 * c) v = (m_os[c] ? 2 : 0) + (m_en[c] ? 1 : 0);
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        m_presc = 0; m_timer = 0; m_ovr = 0; m_irq = 0;
        for (int c = 0; c < CH; c++) begin
            m_period[c] = DP; m_cnt[c] = 0; m_en[c] = (c == 0); m_os[c] = 0; m_pend[c] = 0;
        end
    endtask

    function automatic bit m_fires0();
        return (m_presc == TD - 1) && m_en[0] && (m_period[0] != 0) && (m_cnt[0] + 1 == m_period[0]);
    endfunction

    task automatic model_step(input bit we, input logic [7:0] a, input logic [7:0] d, input bit ack);
        int  off = int'(a) - int'(BASE);
        bit  wr = we && m_mapped(a);
        bit  tick = (m_presc == TD - 1);
        bit  fire [CH];
        bit  any_fire = 0;
        bit  ovr_set = 0;
        if (wr && off == 0) begin
            m_presc = 0; m_timer = 0;
        end else if (tick) begin
            m_presc = 0; m_timer = (m_timer + 1) % (1 << CW);
        end else begin
            m_presc++;
        end
        for (int c = 0; c < CH; c++) begin
            fire[c] = 0;
            if (wr && off == 2 + 2 * c) begin
                m_period[c] = d; m_cnt[c] = 0;
            end else if (wr && off == 3 + 2 * c) begin
                if ((!m_en[c] && d[0]) || tick) m_cnt[c] = 0;
                m_en[c] = d[0]; m_os[c] = d[1];
            end else if (tick && m_en[c] && m_period[c] != 0) begin
                if (m_cnt[c] + 1 == m_period[c]) begin
                    fire[c] = 1; m_cnt[c] = 0;
                    if (m_os[c]) m_en[c] = 0;
                end else begin
                    m_cnt[c]++;
                end
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (fire[c]) begin
                any_fire = 1;
                if (m_pend[c]) ovr_set = 1;
                m_pend[c] = 1;
            end else if (wr && off == 10 && d[c]) begin
                m_pend[c] = 0;
            end
        end
        if (ovr_set) m_ovr = 1;
        else if (wr && off == 10 && d[7]) m_ovr = 0;
        if (any_fire) m_irq = 1;
        else if (ack) m_irq = 0;
    endtask

    // One bus cycle: inputs applied at the negedge, model advanced at the posedge,
    // outputs checked just after the following negedge.
    task automatic cycle(input bit we, input logic [7:0] a, input logic [7:0] d,
                         input bit ack, input bit rst);
        int exp_rd;
        bit rd;
        exp_rd = m_read(a);
        rd = m_mapped(a) && !we && !rst;
        bus_if.BUS_ADDR = a;
        bus_if.BUS_WE = we;
        bus_if.BUS_INTERRUPT_ACK = ack;
        r_wdata = d;
        r_drv = we;
        RESET = rst;
        @(posedge CLK);
        if (rst) model_reset();
        else model_step(we, a, d, ack);
        @(negedge CLK);
        bus_if.BUS_WE = 1'b0;
        bus_if.BUS_INTERRUPT_ACK = 1'b0;
        r_drv = 1'b0;
        RESET = 1'b0;
        #1;
        check_val("raise", int'(bus_if.BUS_INTERRUPT_RAISE), int'(m_irq));
        if (bus_if.BUS_INTERRUPT_RAISE && !prev_raise) rises++;
        prev_raise = bus_if.BUS_INTERRUPT_RAISE;
        if (rd) begin
            check_val($sformatf("rd_driven@%02h", a), int'(bus_float), 0);
            last_rd = BUS_DATA;
            check_val($sformatf("rd@%02h", a), int'(BUS_DATA), exp_rd);
            $display("rd  addr=%02h data=%02h", a, BUS_DATA);
        end else begin
            check_val("bus_z", int'(bus_float), 1);
            if (rst) $display("reset");
            else if (we) $display("wr  addr=%02h data=%02h", a, d);
        end
        last_was_read = rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        cycle(1'b0, a, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cycle(1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic wait_fire0();
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_fires0()) found = 1;
            else idle(1);
        end
        check_val("wait_fire0_timeout", int'(found), 1);
    endtask

    initial begin
        bus_if.BUS_ADDR = 8'h00;
        bus_if.BUS_WE = 1'b0;
        bus_if.BUS_INTERRUPT_ACK = 1'b0;
        prev_raise = 0;
        rises = 0;
        last_was_read = 0;
        model_reset();
        @(negedge CLK);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Reset values
        rd(BASE + 8'd0);  check_val("rst_timer_lo", int'(last_rd), 0);
        rd(BASE + 8'd2);  check_val("rst_period0", int'(last_rd), DP);
        idle(1);
        rd(BASE + 8'd3);  check_val("rst_ctrl0", int'(last_rd), 8'h01);
        rd(BASE + 8'd5);  check_val("rst_ctrl1", int'(last_rd), 8'h00);
        rd(BASE + 8'd10); check_val("rst_status", int'(last_rd), 8'h00);
        rd(BASE + 8'd7);  check_val("unmapped_ch3", int'(last_rd), 8'h00);
        idle(1);

        // Reset abandons a read: issued with reset, and reset during the drive cycle
        cycle(1'b0, BASE + 8'd2, 8'h00, 1'b0, 1'b1);
        rd(BASE + 8'd2);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(1);

        // Periodic ch0, period 3 ticks: events every 12 cycles
        wr(BASE + 8'd0, 8'h00);
        wr(BASE + 8'd2, 8'd3);
        rises = 0;
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 8'h00, prev_raise, 1'b0);
        check_val("ch0_event_count", rises, 3);
        rd(BASE + 8'd10); check_val("status_pend_ovr", int'(last_rd), 8'h81);
        idle(1);
        wr(BASE + 8'd10, 8'h81);
        rd(BASE + 8'd10); check_val("status_cleared", int'(last_rd), 8'h00);
        idle(1);

        // ACK coincident with an event loses; ACK afterwards clears RAISE only
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        wait_fire0();
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_val("ack_vs_event", int'(bus_if.BUS_INTERRUPT_RAISE), 1);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_val("ack_clears", int'(bus_if.BUS_INTERRUPT_RAISE), 0);
        rd(BASE + 8'd10); check_val("status_after_ack", int'(last_rd), 8'h01);
        idle(1);
        wait_fire0();
        idle(1);
        rd(BASE + 8'd10); check_val("status_overrun", int'(last_rd), 8'h81);
        idle(1);
        wr(BASE + 8'd10, 8'h81);
        rd(BASE + 8'd10); check_val("status_w1c", int'(last_rd), 8'h00);
        idle(1);

        // Event beats a write-1-to-clear of the same bit
        wait_fire0();
        wr(BASE + 8'd10, 8'h01);
        rd(BASE + 8'd10); check_val("event_vs_w1c", int'(last_rd), 8'h01);
        idle(1);

        // One-shot ch1 with ch0 disabled
        wr(BASE + 8'd3, 8'h00);
        wr(BASE + 8'd10, 8'h83);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        wr(BASE + 8'd4, 8'd2);
        wr(BASE + 8'd5, 8'h03);
        rises = 0;
        for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00, 8'h00, prev_raise, 1'b0);
        check_val("oneshot_event_count", rises, 1);
        rd(BASE + 8'd5);  check_val("oneshot_ctrl1", int'(last_rd), 8'h02);
        rd(BASE + 8'd10); check_val("oneshot_status", int'(last_rd), 8'h02);
        idle(1);

        // TIMER wrap at 2^9
        begin
            bit found = 0;
            for (int i = 0; i < 2400 && !found; i++) begin
                if (m_timer == 511 && m_presc == 0) found = 1;
                else idle(1);
            end
            check_val("wait_timer_511", int'(found), 1);
        end
        rd(BASE + 8'd1); check_val("timer_hi_511", int'(last_rd), 8'h01);
        rd(BASE + 8'd0); check_val("timer_lo_511", int'(last_rd), 8'hFF);
        begin
            bit found = 0;
            for (int i = 0; i < 10 && !found; i++) begin
                if (m_timer == 0 && m_presc == 0) found = 1;
                else idle(1);
            end
            check_val("wait_timer_wrap", int'(found), 1);
        end
        rd(BASE + 8'd1); check_val("timer_hi_wrap", int'(last_rd), 8'h00);
        rd(BASE + 8'd0); check_val("timer_lo_wrap", int'(last_rd), 8'h00);
        idle(2);
        wr(BASE + 8'd0, 8'h5A);
        idle(3);
        rd(BASE + 8'd0); check_val("timer_clr_pre_tick", int'(last_rd), 8'h00);
        rd(BASE + 8'd0); check_val("timer_clr_first_tick", int'(last_rd), 8'h01);
        idle(1);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [7:0] a;
            logic [7:0] d;
            bit we, ack, rst;
            int off;
            if ($urandom_range(0, 3) != 0) a = BASE + 8'($urandom_range(0, 11));
            else a = 8'($urandom);
            off = int'(a) - int'(BASE);
            we = !last_was_read && ($urandom_range(0, 9) < 3);
            if (we && (off == 2 || off == 4)) d = 8'($urandom_range(0, 6));
            else d = 8'($urandom);
            ack = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle(we, a, d, ack, rst);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
